// File: rtl/adding_machine_datapath_if.sv
// Control-strobe and memory bus between the adding-machine controller and its datapath.
// The controller side drives strobes and read data; the datapath returns address, data and status.
interface adding_machine_datapath_if #(
    parameter int WORD_W = 8,
    parameter int ADR_W  = 6
);
    logic              rd_mem;
    logic              wr_mem;
    logic              ir_on_adr;
    logic              pc_on_adr;
    logic              ld_ir;
    logic              ld_ac;
    logic              ld_pc;
    logic              inc_pc;
    logic              clr_pc;
    logic              pass_add;
    logic [WORD_W-1:0] mem_rdata;

    logic [1:0]        op_code;
    logic [ADR_W-1:0]  adr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] ac_out;
    logic              carry;
    logic              ac_zero;
    logic              bus_err;

    modport master (
        output rd_mem, wr_mem, ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc,
               inc_pc, clr_pc, pass_add, mem_rdata,
        input  op_code, adr, mem_wdata, ac_out, carry, ac_zero, bus_err
    );

    modport slave (
        input  rd_mem, wr_mem, ir_on_adr, pc_on_adr, ld_ir, ld_ac, ld_pc,
               inc_pc, clr_pc, pass_add, mem_rdata,
        output op_code, adr, mem_wdata, ac_out, carry, ac_zero, bus_err
    );
endinterface

// File: rtl/adding_machine_datapath.sv
// Adding-machine datapath: PC/IR/AC registers, add-or-pass ALU, address mux and a sticky
// illegal-strobe flag. Opcode and status leave purely from registers.
module adding_machine_datapath #(
    parameter int WORD_W = 8,
    parameter int ADR_W  = 6   // must be WORD_W-2: opcode sits in the top two IR bits
) (
    input  logic                     clk,
    input  logic                     reset,
    adding_machine_datapath_if.slave bus
);

    logic [ADR_W-1:0]  pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0] ac_q, ac_d;
    logic              carry_q, carry_d;
    logic              bus_err_q, bus_err_d;

    logic [WORD_W-1:0] operand;
    logic [WORD_W:0]   sum;
    logic [WORD_W-1:0] result;
    logic              illegal;

    // Immediate adds take the zero-extended IR address field when memory is not being read.
    always_comb begin
        operand = {{(WORD_W-ADR_W){1'b0}}, ir_q[ADR_W-1:0]};
        if (bus.rd_mem) operand = bus.mem_rdata;
        sum    = {1'b0, ac_q} + {1'b0, operand};
        result = bus.pass_add ? operand : sum[WORD_W-1:0];
    end

    assign illegal = (bus.pc_on_adr & bus.ir_on_adr) | (bus.rd_mem & bus.wr_mem);

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        ac_d      = ac_q;
        carry_d   = carry_q;
        bus_err_d = bus_err_q | illegal;

        if (bus.clr_pc)      pc_d = '0;
        else if (bus.ld_pc)  pc_d = ir_q[ADR_W-1:0];
        else if (bus.inc_pc) pc_d = pc_q + ADR_W'(1);

        if (bus.ld_ir) ir_d = bus.mem_rdata;

        if (bus.ld_ac) begin
            ac_d    = result;
            carry_d = bus.pass_add ? 1'b0 : sum[WORD_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= '0;
            ir_q      <= '0;
            ac_q      <= '0;
            carry_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            ac_q      <= ac_d;
            carry_q   <= carry_d;
            bus_err_q <= bus_err_d;
        end
    end

    // PC wins the address mux when both selects are (illegally) asserted.
    always_comb begin
        bus.adr = '0;
        if (bus.pc_on_adr)      bus.adr = pc_q;
        else if (bus.ir_on_adr) bus.adr = ir_q[ADR_W-1:0];
    end

    assign bus.op_code   = ir_q[WORD_W-1:WORD_W-2];
    assign bus.mem_wdata = ac_q;
    assign bus.ac_out    = ac_q;
    assign bus.carry     = carry_q;
    assign bus.ac_zero   = (ac_q == '0);
    assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_adding_machine_datapath.sv
// Directed bench: a vector table walked from reset, plus hand-written reset and error sequences.
module tb_adding_machine_datapath;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    adding_machine_datapath_if #(.WORD_W(8), .ADR_W(6)) bus ();

    adding_machine_datapath #(.WORD_W(8), .ADR_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // control word bit map: {rd,wr,ir_on,pc_on,ld_ir,ld_ac,ld_pc,inc,clr,pass}
    localparam logic [9:0] RD  = 10'h200, WR  = 10'h100, IRA = 10'h080, PCA = 10'h040,
                           LIR = 10'h020, LAC = 10'h010, LPC = 10'h008, INC = 10'h004,
                           CLR = 10'h002, PAS = 10'h001, NON = 10'h000;

    typedef struct {
        string      name;
        logic [9:0] ctl;
        logic [7:0] rdata;
        logic [5:0] e_adr;   // before the edge
        logic [1:0] e_op;    // after the edge
        logic [7:0] e_ac;
        logic       e_c;
    } vec_t;

    vec_t vt[$];

    function automatic void addv(string n, logic [9:0] c, logic [7:0] d, logic [5:0] a,
                                 logic [1:0] op, logic [7:0] ac, logic cy);
        vec_t v;
        v.name = n; v.ctl = c; v.rdata = d; v.e_adr = a;
        v.e_op = op; v.e_ac = ac; v.e_c = cy;
        vt.push_back(v);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_ctl(logic [9:0] c, logic [7:0] d);
        {bus.rd_mem, bus.wr_mem, bus.ir_on_adr, bus.pc_on_adr, bus.ld_ir,
         bus.ld_ac, bus.ld_pc, bus.inc_pc, bus.clr_pc, bus.pass_add} = c;
        bus.mem_rdata = d;
    endtask

    // drive away from the edge, let the comb settle, then clock it
    task automatic step(logic [9:0] c, logic [7:0] d);
        @(negedge clk);
        set_ctl(c, d);
        #1;
    endtask

    task automatic clk_it();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_ac"},    32'(bus.ac_out),    32'h00);
        chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'h00);
        chk({tag, "_op"},    32'(bus.op_code),   32'h0);
        chk({tag, "_zero"},  32'(bus.ac_zero),   32'h1);
        chk({tag, "_carry"}, 32'(bus.carry),     32'h0);
        chk({tag, "_err"},   32'(bus.bus_err),   32'h0);
        chk({tag, "_adr0"},  32'(bus.adr),       32'h00);
        set_ctl(PCA, 8'h00); #1;
        chk({tag, "_pc"},    32'(bus.adr),       32'h00);
        set_ctl(IRA, 8'h00); #1;
        chk({tag, "_ir"},    32'(bus.adr),       32'h00);
        set_ctl(NON, 8'h00); #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        set_ctl(NON, 8'h00);

        // table walks PC/IR/AC state forward from reset
        addv("ld_ir_05",  RD|LIR,          8'h05, 6'h00, 2'd0, 8'h00, 1'b0);
        addv("ldpc_pri",  LPC|INC|PCA,     8'h00, 6'h00, 2'd0, 8'h00, 1'b0);
        addv("fetch",     PCA|RD|LIR|INC,  8'h47, 6'h05, 2'd1, 8'h00, 1'b0);
        addv("pc_is_6",   PCA,             8'h00, 6'h06, 2'd1, 8'h00, 1'b0);
        addv("ld_ir_4A",  RD|LIR,          8'h4A, 6'h00, 2'd1, 8'h00, 1'b0);
        addv("load_F0",   IRA|RD|LAC|PAS,  8'hF0, 6'h0A, 2'd1, 8'hF0, 1'b0);
        addv("ld_ir_15",  RD|LIR,          8'h15, 6'h00, 2'd0, 8'hF0, 1'b0);
        addv("imm_add",   LAC,             8'hAA, 6'h00, 2'd0, 8'h05, 1'b1);
        addv("ld_ir_C3",  RD|LIR,          8'hC3, 6'h00, 2'd3, 8'h05, 1'b1);
        addv("ldpc_inc",  LPC|INC,         8'h00, 6'h00, 2'd3, 8'h05, 1'b1);
        addv("pc_is_3",   PCA,             8'h00, 6'h03, 2'd3, 8'h05, 1'b1);
        addv("ld_ir_3F",  RD|LIR,          8'h3F, 6'h00, 2'd0, 8'h05, 1'b1);
        addv("ld_pc_3F",  LPC,             8'h00, 6'h00, 2'd0, 8'h05, 1'b1);
        addv("wrap",      PCA|INC,         8'h00, 6'h3F, 2'd0, 8'h05, 1'b1);
        addv("pc_is_0",   PCA|INC,         8'h00, 6'h00, 2'd0, 8'h05, 1'b1);
        addv("clr_ld",    CLR|LPC|PCA,     8'h00, 6'h01, 2'd0, 8'h05, 1'b1);
        addv("inc_from0", INC|PCA,         8'h00, 6'h00, 2'd0, 8'h05, 1'b1);
        addv("hold1",     PCA,             8'h00, 6'h01, 2'd0, 8'h05, 1'b1);
        addv("hold2",     PCA,             8'h00, 6'h01, 2'd0, 8'h05, 1'b1);
        addv("hold3",     PCA,             8'h00, 6'h01, 2'd0, 8'h05, 1'b1);
        addv("ld_ir_8C",  RD|LIR,          8'h8C, 6'h00, 2'd2, 8'h05, 1'b1);
        addv("ld_ac_5A",  RD|LAC|PAS,      8'h5A, 6'h00, 2'd2, 8'h5A, 1'b0);
        addv("store",     IRA|WR|PAS,      8'h00, 6'h0C, 2'd2, 8'h5A, 1'b0);
        addv("pc_kept",   PCA,             8'h00, 6'h01, 2'd2, 8'h5A, 1'b0);
        addv("mem_add",   RD|LIR|LAC,      8'hB0, 6'h00, 2'd2, 8'h0A, 1'b1);
        addv("same_edge", LIR|LAC,         8'h01, 6'h00, 2'd0, 8'h3A, 1'b0);
        addv("to_zero",   RD|LAC,          8'hC6, 6'h00, 2'd0, 8'h00, 1'b1);
        addv("pass_imm",  LAC|PAS,         8'h00, 6'h00, 2'd0, 8'h01, 1'b0);

        // asynchronous reset with no clock edge involved
        #2;
        chk_reset_state("por");
        step(NON, 8'h00);
        reset = 1'b1;
        step(RD|LAC|PAS, 8'h3C);
        clk_it();
        chk("pre_rst_ac", 32'(bus.ac_out), 32'h3C);
        set_ctl(RD|LAC|LIR|INC|PAS, 8'hFF);   // strobes held while reset drops
        #2;
        reset = 1'b0;
        #1;
        chk("async_ac", 32'(bus.ac_out), 32'h00);
        @(posedge clk); #1;
        chk("rst_dom_ac", 32'(bus.ac_out), 32'h00);
        chk("rst_dom_op", 32'(bus.op_code), 32'h0);
        set_ctl(NON, 8'h00);
        chk_reset_state("mid");
        step(NON, 8'h00);
        reset = 1'b1;

        foreach (vt[i]) begin
            step(vt[i].ctl, vt[i].rdata);
            chk({vt[i].name, "_adr"}, 32'(bus.adr), 32'(vt[i].e_adr));
            clk_it();
            chk({vt[i].name, "_op"},    32'(bus.op_code),   32'(vt[i].e_op));
            chk({vt[i].name, "_ac"},    32'(bus.ac_out),    32'(vt[i].e_ac));
            chk({vt[i].name, "_wdata"}, 32'(bus.mem_wdata), 32'(vt[i].e_ac));
            chk({vt[i].name, "_carry"}, 32'(bus.carry),     32'(vt[i].e_c));
            chk({vt[i].name, "_zero"},  32'(bus.ac_zero),   32'(vt[i].e_ac == 8'h00));
            chk({vt[i].name, "_err"},   32'(bus.bus_err),   32'h0);
        end

        // both address selects: PC wins, flag sets, updates still happen
        step(RD|LIR, 8'h02); clk_it();
        step(LPC, 8'h00);    clk_it();
        step(RD|LIR, 8'h11); clk_it();
        step(PCA|IRA|INC, 8'h00);
        chk("err_adr", 32'(bus.adr), 32'h02);
        chk("err_pre", 32'(bus.bus_err), 32'h0);
        clk_it();
        chk("err_set", 32'(bus.bus_err), 32'h1);
        for (int k = 0; k < 5; k++) begin
            step(NON, 8'h00); clk_it();
        end
        chk("err_sticky", 32'(bus.bus_err), 32'h1);
        step(PCA, 8'h00);
        chk("err_no_inhibit", 32'(bus.adr), 32'h03);
        reset = 1'b0; #1;
        chk("err_clr", 32'(bus.bus_err), 32'h0);
        step(NON, 8'h00);
        reset = 1'b1;

        // simultaneous read and write strobes
        step(RD|WR, 8'h00);
        chk("rw_pre", 32'(bus.bus_err), 32'h0);
        clk_it();
        chk("rw_set", 32'(bus.bus_err), 32'h1);
        step(NON, 8'h00); clk_it();
        chk("rw_sticky", 32'(bus.bus_err), 32'h1);
        reset = 1'b0; #1;
        chk("rw_clr", 32'(bus.bus_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adding_machine_datapath.md
Name: adding_machine_datapath

Overview:
- Datapath directly downstream of the adding-machine controller. Consumes its control strobes, holds PC, IR and AC, and drives the memory address and write data.
- Returns the IR opcode field to the controller.
- One-word instruction format: opcode in IR[WORD_W-1:WORD_W-2], address/immediate in IR[ADR_W-1:0].

Parameters:
- WORD_W, 8, data/instruction word width.
- ADR_W, 6, address width; must equal WORD_W-2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- rd_mem  in  1  memory read strobe from controller.
- wr_mem  in  1  memory write strobe from controller.
- ir_on_adr  in  1  select IR address field onto adr.
- pc_on_adr  in  1  select PC onto adr.
- ld_ir  in  1  load IR from mem_rdata.
- ld_ac  in  1  load AC from the ALU result.
- ld_pc  in  1  load PC from the IR address field.
- inc_pc  in  1  increment PC.
- clr_pc  in  1  clear PC.
- pass_add  in  1  1 = ALU passes operand; 0 = ALU computes AC + operand.
- mem_rdata  in  WORD_W  memory read data.
- op_code  out  2  IR[WORD_W-1:WORD_W-2], to controller.
- adr  out  ADR_W  memory address.
- mem_wdata  out  WORD_W  memory write data.
- ac_out  out  WORD_W  current AC value.
- carry  out  1  carry from last add.
- ac_zero  out  1  AC == 0.
- bus_err  out  1  sticky illegal-control-combination flag.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed): PC=0, IR=0, AC=0, carry=0, bus_err=0.
  - Combinational consequences: op_code=0, adr=0 (if no select asserted), mem_wdata=0, ac_out=0, ac_zero=1.
  - Reset dominates all strobes, including mid-instruction.
- All register updates occur on the rising edge of clk while reset=1.

PC:
- Priority clr_pc > ld_pc > inc_pc.
- ld_pc: PC <= IR[ADR_W-1:0].
- inc_pc: PC <= PC+1 mod 2^ADR_W (2^ADR_W-1 wraps to 0).
- No strobe: PC holds.

IR:
- ld_ir: IR <= mem_rdata. Otherwise IR holds.

Operand and ALU:
- operand = mem_rdata when rd_mem=1; otherwise the zero-extended IR[ADR_W-1:0] (immediate add).
- pass_add=1: result = operand.
- pass_add=0: {c, result} = AC + operand, computed at WORD_W+1 bits.

AC and carry:
- ld_ac: AC <= result.
- carry is updated only when ld_ac=1:
  - carry <= c on an add (pass_add=0).
  - carry <= 0 on a pass (pass_add=1).
- ld_ac=0: AC and carry hold.

Same-edge loads:
- ld_ir and ld_ac on the same edge: ALU uses the pre-edge IR/AC.
- ld_pc uses the pre-edge IR.

Address mux (combinational, zero latency):
- pc_on_adr=1: adr = PC (PC has priority when both selects are asserted).
- ir_on_adr=1 only: adr = IR[ADR_W-1:0].
- Neither select: adr = 0.

Write data:
- mem_wdata = AC at all times (combinational); wr_mem is not consumed except for error checking.
- wr_mem never modifies AC.

Error detection:
- bus_err is set on the clock edge where (pc_on_adr & ir_on_adr) | (rd_mem & wr_mem) is true.
- Once set, it stays set until reset.
- An error does not inhibit any register update.

Combinational outputs:
- op_code, ac_out and ac_zero are driven combinationally from the registers.
- No combinational path from any input to op_code.

Test Plan:
- Reset: load AC=8'h3C, then drop reset to 0 between clock edges -> AC=0, PC=0, IR=0, bus_err=0 immediately; ac_zero=1; adr=0 with no select asserted.
- Fetch: PC=5, pc_on_adr=rd_mem=ld_ir=inc_pc=1, mem_rdata=8'h47 -> adr=6'h05 before the edge; after the edge IR=8'h47, op_code=2'b01, PC=6.
- Load then immediate add:
  - Step 1: IR=8'h4A; ir_on_adr=rd_mem=ld_ac=pass_add=1; mem_rdata=8'hF0 -> adr=6'h0A, AC=8'hF0, carry=0.
  - Step 2: IR=8'h15; ld_ac=1, pass_add=0, rd_mem=0 -> AC=8'h05, carry=1, ac_zero=0.
- PC priority and wrap:
  - IR=8'hC3, ld_pc=inc_pc=1 -> PC=6'h03.
  - PC=6'h3F, inc_pc -> PC=0.
  - clr_pc=ld_pc=1 -> PC=0.
  - No strobe for 3 cycles -> PC unchanged.
- Store: AC=8'h5A, IR=8'h8C, ir_on_adr=wr_mem=1, pass_add=1 -> adr=6'h0C, mem_wdata=8'h5A; AC, PC and IR unchanged after the edge; bus_err=0.
- Error:
  - PC=2, IR=8'h11, pc_on_adr=ir_on_adr=1 -> adr=6'h02; bus_err=1 after the edge and still 1 after 5 idle cycles.
  - Separately, rd_mem=wr_mem=1 -> bus_err=1.
  - Cleared only by reset=0.
